// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the rv32i pipeline.
// Issues word fetches, honours decode stall and execute flush, and skids one response.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   output logic [31:0] de_inst,
   output logic [31:0] de_pc,
   output logic [31:0] de_pc_next,
   output logic        de_valid,
   output logic [1:0]  dbg_state
);

   // Memory handshake: a request is live while imem_rmask=4'hF and imem_addr is
   // held until the single-cycle imem_resp strobe; in the response cycle the
   // address may already move on, which memory accepts as the next request.

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DROP  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] pend_pc, pend_pc_n;
   logic [31:0] buf_inst, buf_inst_n;
   logic        buf_valid, buf_valid_n;

   logic        load;
   logic [31:0] load_inst;
   logic [31:0] load_pc;
   logic [3:0]  rmask_c;
   logic [31:0] addr_c;

   logic [31:0] redir;
   logic [31:0] pc_plus4;
   logic [31:0] pc_minus4;
   logic        unused_redirect_lsb;

   assign redir               = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign pc_plus4            = pc + 32'd4;
   assign pc_minus4           = pc - 32'd4;

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      pend_pc_n   = pend_pc;
      buf_inst_n  = buf_inst;
      buf_valid_n = buf_valid;
      load        = 1'b0;
      load_inst   = NOP;
      load_pc     = pc;
      rmask_c     = 4'h0;
      addr_c      = pc;

      case (state)
         S_FETCH: begin
            rmask_c = 4'hF;
            if (imem_resp && flush) begin
               pc_n   = redir;
               addr_c = redir;
            end else if (imem_resp && stall) begin
               // Decode cannot take the word: park it and stop requesting.
               buf_inst_n  = imem_rdata;
               buf_valid_n = 1'b1;
               pc_n        = pc_plus4;
               rmask_c     = 4'h0;
               state_n     = S_HOLD;
            end else if (imem_resp) begin
               load      = 1'b1;
               load_inst = imem_rdata;
               load_pc   = pc;
               pc_n      = pc_plus4;
               addr_c    = pc_plus4;
            end else if (flush) begin
               pend_pc_n = redir;
               state_n   = S_DROP;
            end
         end

         S_DROP: begin
            // The stale request must complete before the redirect is issued.
            rmask_c = 4'hF;
            if (imem_resp) begin
               pc_n    = flush ? redir : pend_pc;
               addr_c  = flush ? redir : pend_pc;
               state_n = S_FETCH;
            end else if (flush) begin
               pend_pc_n = redir;
            end
         end

         S_HOLD: begin
            if (flush) begin
               buf_valid_n = 1'b0;
               pc_n        = redir;
               state_n     = S_FETCH;
            end else if (!stall) begin
               load        = 1'b1;
               load_inst   = buf_inst;
               load_pc     = pc_minus4;
               buf_valid_n = 1'b0;
               state_n     = S_FETCH;
            end
         end

         default: begin
            state_n = S_FETCH;
         end
      endcase
   end

   assign imem_rmask = rst ? 4'h0 : rmask_c;
   assign imem_addr  = addr_c;
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         pend_pc   <= 32'd0;
         buf_inst  <= 32'd0;
         buf_valid <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         pend_pc   <= pend_pc_n;
         buf_inst  <= buf_inst_n;
         buf_valid <= buf_valid_n;
      end
   end

   // IF/ID register: flush beats stall beats load; otherwise a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_valid <= 1'b0;
         de_inst  <= NOP;
         de_pc    <= 32'd0;
      end else if (flush) begin
         de_valid <= 1'b0;
         de_inst  <= NOP;
      end else if (stall) begin
         de_valid <= de_valid;
      end else if (load) begin
         de_valid <= 1'b1;
         de_inst  <= load_inst;
         de_pc    <= load_pc;
      end else begin
         de_valid <= 1'b0;
         de_inst  <= NOP;
      end
   end

   assign de_pc_next = de_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each row drives one cycle of
// stall/flush/memory response and states the outputs expected in that cycle.
module tb_fetch_stage;

   localparam logic [31:0] R   = 32'h6000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [3:0]  F   = 4'hF;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] de_inst;
   logic [31:0] de_pc;
   logic [31:0] de_pc_next;
   logic        de_valid;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(R)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rmask  (imem_rmask),
      .imem_rdata  (imem_rdata),
      .imem_resp   (imem_resp),
      .de_inst     (de_inst),
      .de_pc       (de_pc),
      .de_pc_next  (de_pc_next),
      .de_valid    (de_valid),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] rpc;
      logic        resp;
      logic [31:0] rdata;
      logic [3:0]  e_rmask;
      logic [31:0] e_addr;
      logic        e_dv;
      logic [31:0] e_di;
      logic [31:0] e_dpc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic s, input logic f, input logic [31:0] rpc,
                               input logic r, input logic [31:0] rd,
                               input logic [3:0] em, input logic [31:0] ea,
                               input logic edv, input logic [31:0] edi,
                               input logic [31:0] edpc);
      vec_t v;
      v.stall = s;  v.flush = f;  v.rpc = rpc;  v.resp = r;  v.rdata = rd;
      v.e_rmask = em;  v.e_addr = ea;  v.e_dv = edv;  v.e_di = edi;  v.e_dpc = edpc;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic f, input logic [31:0] rpc,
                        input logic r, input logic [31:0] rd);
      stall = s;  flush = f;  redirect_pc = rpc;  imem_resp = r;  imem_rdata = rd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1-cycle memory, stall on resp for ..08, HOLD release bubble
      add(0,0,0,           0,0,            F,   R,            0,NOP,          0);
      add(0,0,0,           1,R,            F,   R+32'h4,      0,NOP,          0);
      add(0,0,0,           1,R+32'h4,      F,   R+32'h8,      1,R,            R);
      add(1,0,0,           1,R+32'h8,      4'h0,R+32'h8,      1,R+32'h4,      R+32'h4);
      add(1,0,0,           0,0,            4'h0,R+32'hC,      1,R+32'h4,      R+32'h4);
      add(0,0,0,           0,0,            4'h0,R+32'hC,      1,R+32'h4,      R+32'h4);
      add(0,0,0,           0,0,            F,   R+32'hC,      1,R+32'h8,      R+32'h8);
      add(0,0,0,           1,R+32'hC,      F,   R+32'h10,     0,NOP,          R+32'h8);
      // flush to ..1000 while ..10 outstanding, 3-cycle latency
      add(0,1,R+32'h1000,  0,0,            F,   R+32'h10,     1,R+32'hC,      R+32'hC);
      add(0,0,0,           0,0,            F,   R+32'h10,     0,NOP,          R+32'hC);
      add(0,0,0,           1,R+32'h10,     F,   R+32'h1000,   0,NOP,          R+32'hC);
      add(0,0,0,           0,0,            F,   R+32'h1000,   0,NOP,          R+32'hC);
      add(0,0,0,           0,0,            F,   R+32'h1000,   0,NOP,          R+32'hC);
      add(0,0,0,           1,R+32'h1000,   F,   R+32'h1004,   0,NOP,          R+32'hC);
      add(0,0,0,           0,0,            F,   R+32'h1004,   1,R+32'h1000,   R+32'h1000);
      // flush coincident with resp, then flush during HOLD
      add(0,1,R+32'h2000,  1,R+32'h1004,   F,   R+32'h2000,   0,NOP,          R+32'h1000);
      add(1,0,0,           1,R+32'h2000,   4'h0,R+32'h2000,   0,NOP,          R+32'h1000);
      add(1,1,R+32'h2000,  0,0,            4'h0,R+32'h2004,   0,NOP,          R+32'h1000);
      add(0,0,0,           0,0,            F,   R+32'h2000,   0,NOP,          R+32'h1000);
      add(0,0,0,           1,R+32'h2000,   F,   R+32'h2004,   0,NOP,          R+32'h1000);
      // DROP with overwritten redirect (low bits forced 0), then wrap
      add(0,1,R+32'h3000,  0,0,            F,   R+32'h2004,   1,R+32'h2000,   R+32'h2000);
      add(0,1,32'hFFFF_FFFE,0,0,           F,   R+32'h2004,   0,NOP,          R+32'h2000);
      add(0,0,0,           1,R+32'h2004,   F,   32'hFFFF_FFFC,0,NOP,          R+32'h2000);
      add(0,0,0,           1,32'hFFFF_FFFC,F,   32'h0,        0,NOP,          R+32'h2000);
      add(0,0,0,           0,0,            F,   32'h0,        1,32'hFFFF_FFFC,32'hFFFF_FFFC);
      // flush and resp coincide in DROP: redirect_pc wins over pend_pc
      add(0,1,R+32'h4000,  0,0,            F,   32'h0,        0,NOP,          32'hFFFF_FFFC);
      add(0,1,R+32'h5000,  1,32'h0,        F,   R+32'h5000,   0,NOP,          32'hFFFF_FFFC);
      add(0,0,0,           1,R+32'h5000,   F,   R+32'h5004,   0,NOP,          32'hFFFF_FFFC);
      // stall without resp holds IF/ID; stall+flush together clears it
      add(1,0,0,           0,0,            F,   R+32'h5004,   1,R+32'h5000,   R+32'h5000);
      add(1,1,R+32'h6000,  0,0,            F,   R+32'h5004,   1,R+32'h5000,   R+32'h5000);
      add(0,0,0,           1,R+32'h5004,   F,   R+32'h6000,   0,NOP,          R+32'h5000);
      add(0,0,0,           0,0,            F,   R+32'h6000,   0,NOP,          R+32'h5000);

      rst = 1'b1;
      drive(0, 0, 32'd0, 0, 32'd0);
      repeat (3) next_cycle();
      @(negedge clk);
      chk("reset_rmask",   {28'd0, imem_rmask}, 32'h0);
      chk("reset_valid",   {31'd0, de_valid},   32'h0);
      chk("reset_inst",    de_inst,             NOP);
      chk("reset_pc",      de_pc,               32'h0);
      chk("reset_pc_next", de_pc_next,          32'h4);
      next_cycle();
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].rpc, vecs[i].resp, vecs[i].rdata);
         @(negedge clk);
         chk($sformatf("rmask_c%0d", i),   {28'd0, imem_rmask}, {28'd0, vecs[i].e_rmask});
         chk($sformatf("addr_c%0d", i),    imem_addr,           vecs[i].e_addr);
         chk($sformatf("valid_c%0d", i),   {31'd0, de_valid},   {31'd0, vecs[i].e_dv});
         chk($sformatf("inst_c%0d", i),    de_inst,             vecs[i].e_di);
         chk($sformatf("pc_c%0d", i),      de_pc,               vecs[i].e_dpc);
         chk($sformatf("pc_next_c%0d", i), de_pc_next,          vecs[i].e_dpc + 32'd4);
         next_cycle();
      end

      // reset mid-operation with a request to ..6000 outstanding
      drive(0, 0, 32'd0, 0, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rmask", {28'd0, imem_rmask}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("midrst_valid", {31'd0, de_valid}, 32'h0);
      chk("midrst_inst",  de_inst,           NOP);
      chk("midrst_pc",    de_pc,             32'h0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_rmask",   {28'd0, imem_rmask}, {28'd0, F});
      chk("postrst_addr",    imem_addr,           R);
      chk("postrst_pc_next", de_pc_next,          32'h4);
      next_cycle();
      drive(0, 0, 32'd0, 1, R);
      @(negedge clk);
      chk("postrst_next_addr", imem_addr, R + 32'h4);
      next_cycle();
      drive(0, 0, 32'd0, 0, 32'd0);
      @(negedge clk);
      chk("postrst_valid", {31'd0, de_valid}, 32'h1);
      chk("postrst_inst",  de_inst,           R);
      chk("postrst_de_pc", de_pc,             R);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
